alu_issue_stage: RTL and testbench

- ID/EX issue stage sitting directly upstream of the 32-bit ALU.
- Accepts decoded instruction fields and decodes the MIPS ALUOp/funct pair into the 4-bit ALU control word.
- Selects the B operand (register or extended immediate) and registers the A operand, B operand and control word for the ALU.
- Uses a valid/ready handshake with a 2-entry skid buffer, so downstream back-pressure never drops or duplicates an operation.

---
 rtl/alu_issue_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the 32-bit ALU.
// Decodes ALUOp/funct into the 4-bit ALU control word. Selects operand B from the register or
// the extended immediate. Holds up to two decoded operations: an output register plus one skid
// entry. in_ready depends only on registered state, so out_ready never reaches it
// combinationally.
// Optional feature: define ALU_ISSUE_FWD_EN to add operand forwarding muxes ahead of the
// immediate mux.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [WIDTH-1:0] in_rt,
  input  logic [IMM_W-1:0] in_imm,
  input  logic             in_alu_src,
  input  logic             in_zero_ext,
  input  logic [1:0]       in_alu_op,
  input  logic [5:0]       in_funct,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] fwd_exmem,
  input  logic [WIDTH-1:0] fwd_memwb,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [3:0]       out_ctl,
  output logic             out_illegal
);

  // Occupancy encoded as {out_valid, skid_valid}; 01 cannot occur.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [3:0]       out_ctl_q, out_ctl_d;
  logic             out_ill_q, out_ill_d;

  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_a_q, skid_a_d;
  logic [WIDTH-1:0] skid_b_q, skid_b_d;
  logic [3:0]       skid_ctl_q, skid_ctl_d;
  logic             skid_ill_q, skid_ill_d;

  logic             accept;
  logic             emit;
  state_e           state;

  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] dec_a;
  logic [WIDTH-1:0] dec_b;
  logic [3:0]       dec_ctl;
  logic             dec_ill;

  assign in_ready = ~skid_valid_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign emit     = out_valid_q & out_ready;
  assign state    = state_e'({out_valid_q, skid_valid_q});

`ifdef ALU_ISSUE_FWD_EN
  // Forwarding selection on register operands; 11 falls back to the register value.
  always_comb begin
    reg_a = in_rs;
    reg_b = in_rt;
    case (fwd_a_sel)
      2'b01:   reg_a = fwd_exmem;
      2'b10:   reg_a = fwd_memwb;
      default: reg_a = in_rs;
    endcase
    case (fwd_b_sel)
      2'b01:   reg_b = fwd_exmem;
      2'b10:   reg_b = fwd_memwb;
      default: reg_b = in_rt;
    endcase
  end
`else
  assign reg_a = in_rs;
  assign reg_b = in_rt;
`endif

  // Immediate extension and B selection; the immediate wins over any forwarded value.
  always_comb begin
    if (in_zero_ext) begin
      ext_imm = {{(WIDTH-IMM_W){1'b0}}, in_imm};
    end else begin
      ext_imm = {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    end
    dec_a = reg_a;
    dec_b = in_alu_src ? ext_imm : reg_b;
  end

  // ALUOp/funct decode into {Ainvert, Binvert, op[1:0]}.
  always_comb begin
    dec_ctl = 4'b0010;
    dec_ill = 1'b0;
    unique case (in_alu_op)
      2'b00: dec_ctl = 4'b0010;
      2'b01: dec_ctl = 4'b0110;
      2'b11: dec_ctl = 4'b0001;
      2'b10: begin
        case (in_funct)
          6'b100000: dec_ctl = 4'b0010;
          6'b100010: dec_ctl = 4'b0110;
          6'b100100: dec_ctl = 4'b0000;
          6'b100101: dec_ctl = 4'b0001;
          6'b101010: dec_ctl = 4'b0111;
          6'b100111: dec_ctl = 4'b1100;
          default: begin
            dec_ctl = 4'b0010;
            dec_ill = 1'b1;
          end
        endcase
      end
      default: dec_ctl = 4'b0010;
    endcase
  end

  // Next-state for output register and skid entry; flush drops everything including this
  // cycle's accept.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_ctl_d    = out_ctl_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    skid_ctl_d   = skid_ctl_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state)
        StEmpty: begin
          if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = dec_a;
            out_b_d     = dec_b;
            out_ctl_d   = dec_ctl;
            out_ill_d   = dec_ill;
          end
        end
        StOne: begin
          if (accept && emit) begin
            out_a_d   = dec_a;
            out_b_d   = dec_b;
            out_ctl_d = dec_ctl;
            out_ill_d = dec_ill;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_a_d     = dec_a;
            skid_b_d     = dec_b;
            skid_ctl_d   = dec_ctl;
            skid_ill_d   = dec_ill;
          end else if (emit) begin
            out_valid_d = 1'b0;
          end
        end
        StFull: begin
          if (emit) begin
            skid_valid_d = 1'b0;
            out_a_d      = skid_a_q;
            out_b_d      = skid_b_q;
            out_ctl_d    = skid_ctl_q;
            out_ill_d    = skid_ill_q;
          end
        end
        default: begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_ctl_q    <= 4'b0000;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
      skid_ctl_q   <= 4'b0000;
      skid_ill_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_ctl_q    <= out_ctl_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
      skid_ctl_q   <= skid_ctl_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_ctl     = out_ctl_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios with literal expectations, then random traffic
// compared every cycle against a 2-deep FIFO model of decoded operations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_rs, in_rt;
  logic [15:0] in_imm;
  logic        in_alu_src, in_zero_ext;
  logic [1:0]  in_alu_op;
  logic [5:0]  in_funct;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_ctl;
`ifdef ALU_ISSUE_FWD_EN
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] fwd_exmem, fwd_memwb;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(32), .IMM_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_imm      (in_imm),
    .in_alu_src  (in_alu_src),
    .in_zero_ext (in_zero_ext),
    .in_alu_op   (in_alu_op),
    .in_funct    (in_funct),
`ifdef ALU_ISSUE_FWD_EN
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .fwd_exmem   (fwd_exmem),
    .fwd_memwb   (fwd_memwb),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_ctl     (out_ctl),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef ALU_ISSUE_FWD_EN
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'd1) return fwd_exmem;
    if (sel == 2'd2) return fwd_memwb;
    return r;
  endfunction
`endif

  // What the stage must produce for the inputs currently presented.
  function automatic ent_t model_entry();
    ent_t        e;
    logic [31:0] ra, rb, ext;
    ra = in_rs;
    rb = in_rt;
`ifdef ALU_ISSUE_FWD_EN
    ra = pick(fwd_a_sel, in_rs);
    rb = pick(fwd_b_sel, in_rt);
`endif
    ext   = in_zero_ext ? 32'(in_imm) : 32'($signed(in_imm));
    e.a   = ra;
    e.b   = in_alu_src ? ext : rb;
    e.ill = 1'b0;
    e.ctl = 4'd2;
    if (in_alu_op == 2'd1) e.ctl = 4'd6;
    else if (in_alu_op == 2'd3) e.ctl = 4'd1;
    else if (in_alu_op == 2'd2) begin
      if (in_funct == 6'h20) e.ctl = 4'd2;
      else if (in_funct == 6'h22) e.ctl = 4'd6;
      else if (in_funct == 6'h24) e.ctl = 4'd0;
      else if (in_funct == 6'h25) e.ctl = 4'd1;
      else if (in_funct == 6'h2a) e.ctl = 4'd7;
      else if (in_funct == 6'h27) e.ctl = 4'd12;
      else e.ill = 1'b1;
    end
    return e;
  endfunction

  // FIFO of at most two pending operations; emit pops, accept pushes.
  task automatic model_step();
    bit acc, emit;
    acc  = in_valid && q.size() < 2 && !rst && !flush;
    emit = out_ready && q.size() != 0;
    if (rst || flush) q.delete();
    else begin
      if (emit) void'(q.pop_front());
      if (acc) q.push_back(model_entry());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic v, input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input logic src, input logic zext);
    in_valid = v; in_alu_op = op; in_funct = fn; in_rs = rs; in_rt = rt;
    in_imm = imm; in_alu_src = src; in_zero_ext = zext;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2 && !rst));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_a", out_a, q[0].a);
        chk("out_b", out_b, q[0].b);
        chk("out_ctl", 32'(out_ctl), 32'(q[0].ctl));
        chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      end
    end
  end

  logic [5:0] functs [8];

  initial begin
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h08, 6'h3f};
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    send(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
`ifdef ALU_ISSUE_FWD_EN
    fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; fwd_exmem = 32'd0; fwd_memwb = 32'd0;
`endif
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_ctl", 32'(out_ctl), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);

    // R-type add
    rst = 1'b0; out_ready = 1'b1;
    send(1'b1, 2'd2, 6'h20, 32'd5, 32'd7, 16'd0, 1'b0, 1'b0);
    tick();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_ctl", 32'(out_ctl), 32'b0010);
    chk("add_ill", 32'(out_illegal), 32'd0);

    // Sign vs zero extension, back to back
    send(1'b1, 2'd0, 6'h00, 32'd1, 32'd2, 16'hFFFC, 1'b1, 1'b0);
    tick();
    chk("sext_b", out_b, 32'hFFFFFFFC);
    send(1'b1, 2'd0, 6'h00, 32'd1, 32'd2, 16'hFFFC, 1'b1, 1'b1);
    tick();
    chk("zext_b", out_b, 32'h0000FFFC);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: slt then nor
    out_ready = 1'b0;
    send(1'b1, 2'd2, 6'h2a, 32'd1, 32'd2, 16'd0, 1'b0, 1'b0);
    tick();
    chk("slt_ctl", 32'(out_ctl), 32'b0111);
    send(1'b1, 2'd2, 6'h27, 32'd3, 32'd4, 16'd0, 1'b0, 1'b0);
    tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("hold_ctl", 32'(out_ctl), 32'b0111);
    chk("hold_a", out_a, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("nor_ctl", 32'(out_ctl), 32'b1100);
    chk("nor_a", out_a, 32'd3);
    chk("nor_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("no_dup_valid", 32'(out_valid), 32'd0);

    // Flush from FULL, then flush discarding a same-cycle accept
    out_ready = 1'b0;
    send(1'b1, 2'd2, 6'h20, 32'd10, 32'd20, 16'd0, 1'b0, 1'b0);
    tick();
    send(1'b1, 2'd2, 6'h22, 32'd30, 32'd40, 16'd0, 1'b0, 1'b0);
    tick();
    chk("pre_flush_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    send(1'b1, 2'd2, 6'h24, 32'd50, 32'd60, 16'd0, 1'b0, 1'b0);
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flushed_never_out", 32'(out_valid), 32'd0);

    // Illegal funct, then beq
    send(1'b1, 2'd2, 6'h08, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0);
    tick();
    chk("ill_ctl", 32'(out_ctl), 32'b0010);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    send(1'b1, 2'd1, 6'h08, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0);
    tick();
    chk("beq_ctl", 32'(out_ctl), 32'b0110);
    chk("beq_ill", 32'(out_illegal), 32'd0);

`ifdef ALU_ISSUE_FWD_EN
    fwd_b_sel = 2'd1; fwd_exmem = 32'h1234;
    send(1'b1, 2'd0, 6'h00, 32'd9, 32'd9, 16'd3, 1'b0, 1'b0);
    tick();
    chk("fwd_b", out_b, 32'h1234);
    send(1'b1, 2'd0, 6'h00, 32'd9, 32'd9, 16'd3, 1'b1, 1'b0);
    tick();
    chk("fwd_imm_wins", out_b, 32'd3);
    fwd_b_sel = 2'd0;
`endif
    in_valid = 1'b0;
    tick();

    // Random traffic checked by the per-cycle compare
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 150) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      send($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), functs[$urandom_range(0, 7)],
           $urandom, $urandom, 16'($urandom), 1'($urandom), 1'($urandom));
`ifdef ALU_ISSUE_FWD_EN
      fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
      fwd_exmem = $urandom; fwd_memwb = $urandom;
`endif
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
